// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a power-of-two TX FIFO.
//
// Serialises FIFO words as frames:
//   start bit (0), 5..8 data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
// The frame format is latched when a word is popped, so config changes only
// affect the next frame.
//
// Ports:
//   clk_i         system clock
//   rst_ni        synchronous active-low reset
//   baud_div_i    clock cycles per bit (0 behaves as 1)
//   data_bits_i   data width code: 0=5, 1=6, 2=7, 3=8
//   parity_en_i   append parity bit
//   parity_odd_i  1 = odd parity, 0 = even parity
//   stop2_i       1 = two stop bits
//   tx_en_i       enable; while low the baud counter and line hold
//   tx_we_i       FIFO write strobe (dropped when full)
//   din_i         write data
//   flush_i       clear FIFO (does not abort the frame on the line)
//   full_o        FIFO full
//   empty_o       FIFO empty
//   level_o       FIFO occupancy 0..DEPTH
//   busy_o        frame in progress
//   tx_bit_o      serial line, registered, idle high
module uart_tx_cfg #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DIV_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DIV_W-1:0]         baud_div_i,
  input  logic [1:0]               data_bits_i,
  input  logic                     parity_en_i,
  input  logic                     parity_odd_i,
  input  logic                     stop2_i,
  input  logic                     tx_en_i,
  input  logic                     tx_we_i,
  input  logic [7:0]               din_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic                     tx_bit_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        empty, full, push, pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Flush wins over a same-cycle write.
  assign push    = tx_we_i && !full && !flush_i;
  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // ---------------------------------------------------------------------------
  // Baud tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt_q, cnt_d, div_m1;
  logic             tick;

  assign div_m1 = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
  // >= so a divisor lowered while the counter is above it wraps immediately
  // instead of running through the whole counter range.
  assign tick   = tx_en_i && (cnt_q >= div_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (tick)         cnt_d = '0;
    else if (tx_en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic       busy_q;
  logic       tx_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [1:0] nbits_q;
  logic       par_en_q;
  logic       par_q;      // running parity, seeded with the odd flag
  logic       stop2_q;
  logic       stop_cnt_q;
  logic       last_stop;
  logic       last_data;

  assign last_stop = (state_q == S_STOP) && (!stop2_q || stop_cnt_q);
  assign last_data = (bit_cnt_q == ({1'b0, nbits_q} + 3'd4));
  // Pops happen only from IDLE or at the final stop tick; a flush in the
  // same cycle suppresses the pop so no flushed word reaches the line.
  assign pop       = tick && !empty && !flush_i &&
                     ((state_q == S_IDLE) || last_stop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else if (tick) begin
      if (pop) begin
        shift_q  <= mem_q[rd_ptr_q[AW-1:0]];
        nbits_q  <= data_bits_i;
        par_en_q <= parity_en_i;
        par_q    <= parity_odd_i;
        stop2_q  <= stop2_i;
        state_q  <= S_START;
        busy_q   <= 1'b1;
        tx_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_START: begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
            par_q     <= par_q ^ shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
          end
          S_DATA: begin
            if (last_data) begin
              stop_cnt_q <= 1'b0;
              if (par_en_q) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[0];
              par_q     <= par_q ^ shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end
          S_PARITY: begin
            state_q    <= S_STOP;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
          end
          S_STOP: begin
            if (!last_stop) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign tx_bit_o = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg (DEPTH=4 instance).
// Stimulus pushes hand-described frames into a scoreboard queue; a monitor
// reconstructs the expected line waveform per frame and checks every bit slot.
module tb_uart_tx_cfg;

  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_bits;
  logic             parity_en, parity_odd, stop2, tx_en, tx_we, flush;
  logic [7:0]       din;
  logic             full, empty, busy, tx_bit;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .baud_div_i   (baud_div),
    .data_bits_i  (data_bits),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .tx_en_i      (tx_en),
    .tx_we_i      (tx_we),
    .din_i        (din),
    .flush_i      (flush),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .busy_o       (busy),
    .tx_bit_o     (tx_bit)
  );

  typedef struct {
    logic [7:0] data;
    int         nb;
    bit         pen;
    bit         par;   // hand-computed parity bit value
    bit         s2;
    int         div;
  } frame_t;

  frame_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic en_q   = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= tx_en;
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit   mon_en   = 0;
  bit   in_frame = 0;
  bit   junk     = 0;
  int   s, bi, bad, nbits_tot, div_cur;
  logic exp_bits [0:11];
  int   frames_done = 0;
  int   start_cyc[$];
  int   end_cyc[$];
  frame_t cur;

  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      in_frame = 0;
      junk     = 0;
    end else begin
      if (in_frame) begin
        if (en_q) s++;
        if (s / div_cur != bi) begin
          checks++;
          if (bad != 0) begin
            failures++;
            $display("FAIL frame_bit: frame %0d slot %0d wrong in %0d samples, required %0b",
                     frames_done, bi, bad, exp_bits[bi]);
          end
          bi  = s / div_cur;
          bad = 0;
        end
        if (bi == nbits_tot) begin
          in_frame = 0;
          frames_done++;
          end_cyc.push_back(cyc);
        end else if (tx_bit !== exp_bits[bi]) begin
          bad++;
        end
      end
      if (junk && tx_bit === 1'b1) junk = 0;
      if (!in_frame && !junk && tx_bit !== 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          junk = 1;
          $display("FAIL unexpected_frame: line=%b at cycle %0d, required idle 1", tx_bit, cyc);
        end else begin
          int n;
          cur = sb.pop_front();
          n = 0;
          exp_bits[n] = 1'b0; n++;
          for (int i = 0; i < cur.nb; i++) begin
            exp_bits[n] = cur.data[i]; n++;
          end
          if (cur.pen) begin exp_bits[n] = cur.par; n++; end
          exp_bits[n] = 1'b1; n++;
          if (cur.s2) begin exp_bits[n] = 1'b1; n++; end
          nbits_tot = n;
          div_cur   = cur.div;
          s = 0; bi = 0; bad = 0;
          in_frame = 1;
          start_cyc.push_back(cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic cfg(input int div, input int db, input bit pe, input bit po, input bit s2);
    baud_div   = DIV_W'(div);
    data_bits  = 2'(db);
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
  endtask

  task automatic write(input logic [7:0] d);
    tx_we = 1'b1; din = d;
    step(1);
    tx_we = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int nb, input bit pen,
                              input bit par, input bit s2, input int div);
    frame_t f;
    f.data = d; f.nb = nb; f.pen = pen; f.par = par; f.s2 = s2; f.div = div;
    sb.push_back(f);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (frames_done < n && k < budget) begin step(1); k++; end
    check(name, frames_done, n);
  endtask

  task automatic wait_busy(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b1 && k < budget) begin step(1); k++; end
    check(name, int'(busy), 1);
  endtask

  task automatic wait_slot(input int slot, input int budget, input string name);
    int k = 0;
    while (!(in_frame && bi == slot) && k < budget) begin step(1); k++; end
    check(name, (in_frame && bi == slot) ? 1 : 0, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int bc, lvl_pop, f0;
    bit seen;

    rst_n = 1'b0; tx_en = 1'b0; tx_we = 1'b0; flush = 1'b0; din = '0;
    cfg(4, 3, 0, 0, 0);
    step(3);
    rst_n = 1'b1;
    mon_en = 1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      check("reset_idle", int'({tx_bit, busy, empty, full, level}), 7'b1010000);
      step(1);
    end

    // 8N1, div 4, 0x55
    cfg(4, 3, 0, 0, 0);
    tx_en = 1'b1;
    expect_frame(8'h55, 8, 0, 0, 0, 4);
    write(8'h55);
    check("level_after_write", int'(level), 1);
    bc = 0; seen = 0; lvl_pop = -1;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (busy) begin
        if (!seen) lvl_pop = int'(level);
        seen = 1; bc++;
      end else if (seen) break;
    end
    check("level_at_pop", lvl_pop, 0);
    check("busy_len_8n1", bc, 40);
    wait_frames(1, 50, "frames_8n1");
    check("frame_len_8n1", end_cyc[0] - start_cyc[0], 40);

    // 7E2, div 3, 0x83 (bit 7 ignored); config changed mid-frame has no effect
    cfg(3, 2, 1, 0, 1);
    expect_frame(8'h83, 7, 1, 0, 1, 3);
    write(8'h83);
    wait_busy(20, "busy_7e2");
    cfg(3, 3, 0, 1, 0);
    wait_frames(2, 100, "frames_7e2");
    check("frame_len_7e2", end_cyc[1] - start_cyc[1], 33);

    // 5O1, div 2, 0x1F
    cfg(2, 0, 1, 1, 0);
    expect_frame(8'h1F, 5, 1, 0, 0, 2);
    write(8'h1F);
    wait_frames(3, 100, "frames_5o1");
    check("frame_len_5o1", end_cyc[2] - start_cyc[2], 16);

    // Fill FIFO with transmitter disabled, then drain back-to-back
    tx_en = 1'b0;
    step(2);
    cfg(2, 3, 0, 0, 0);
    write(8'hA1); write(8'hA2); write(8'hA3);
    check("not_full_at_3", int'(full), 0);
    write(8'hA4);
    check("full_after_4", int'(full), 1);
    check("level_4", int'(level), 4);
    write(8'hA5);
    check("level_after_drop", int'(level), 4);
    check("full_after_drop", int'(full), 1);
    expect_frame(8'hA1, 8, 0, 0, 0, 2);
    expect_frame(8'hA2, 8, 0, 0, 0, 2);
    expect_frame(8'hA3, 8, 0, 0, 0, 2);
    expect_frame(8'hA4, 8, 0, 0, 0, 2);
    tx_en = 1'b1;
    wait_frames(7, 200, "frames_burst");
    for (int k = 3; k < 6; k++)
      check("no_gap", start_cyc[k+1] - end_cyc[k], 0);
    check("empty_after_burst", int'(empty), 1);

    // Pause tx_en during data bit 3 (slot 4) of 0x3C
    cfg(4, 3, 0, 0, 0);
    expect_frame(8'h3C, 8, 0, 0, 0, 4);
    write(8'h3C);
    wait_slot(4, 100, "reach_bit3");
    tx_en = 1'b0;
    step(10);
    check("pause_hold", int'(tx_bit), 1);
    tx_en = 1'b1;
    wait_frames(8, 100, "frames_pause");
    check("frame_len_pause", end_cyc[7] - start_cyc[7], 50);

    // Flush mid-frame, with a same-cycle write that must be discarded
    expect_frame(8'h11, 8, 0, 0, 0, 4);
    write(8'h11); write(8'h22); write(8'h33);
    wait_busy(20, "busy_flush");
    check("level_before_flush", int'(level), 2);
    flush = 1'b1; tx_we = 1'b1; din = 8'h44;
    step(1);
    flush = 1'b0; tx_we = 1'b0;
    check("level_after_flush", int'(level), 0);
    check("empty_after_flush", int'(empty), 1);
    check("busy_after_flush", int'(busy), 1);
    wait_frames(9, 100, "frames_flush");
    step(30);
    check("idle_after_flush", int'(busy), 0);
    check("no_extra_frames", frames_done, 9);

    // Reset mid-frame
    expect_frame(8'h00, 8, 0, 0, 0, 4);
    write(8'h00);
    wait_slot(3, 100, "reach_reset_point");
    f0 = frames_done;
    mon_en = 0;
    rst_n = 1'b0;
    step(1);
    check("reset_line_high", int'(tx_bit), 1);
    check("reset_busy_low", int'(busy), 0);
    rst_n = 1'b1;
    step(2);
    mon_en = 1;
    step(40);
    check("no_frame_after_reset", frames_done, f0);
    check("line_idle_after_reset", int'(tx_bit), 1);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor to the core's fixed 8N1 UART transmitter.
- Holds a power-of-two TX FIFO and serialises frames with run-time selectable data width (5-8), parity (none/even/odd) and stop bits (1/2).
- Reports FIFO fill level and busy status for the peripheral register block.
- Sits between the UART register interface (writes, config) and the TX pad.

Parameters:
- DEPTH, 32, FIFO entries; power of two, >= 2.
- DIV_W, 16, width of baud divisor.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous active-low reset
- baud_div_i  input  DIV_W  clock cycles per bit; value 0 treated as 1
- data_bits_i  input  2  data bits: 0=5, 1=6, 2=7, 3=8
- parity_en_i  input  1  1 = parity bit appended
- parity_odd_i  input  1  1 = odd parity, 0 = even parity
- stop2_i  input  1  1 = two stop bits, 0 = one stop bit
- tx_en_i  input  1  transmitter enable; gates baud ticks
- tx_we_i  input  1  FIFO write strobe
- din_i  input  8  write data; bits above the selected width are ignored
- flush_i  input  1  clear FIFO
- full_o  output  1  FIFO full
- empty_o  output  1  FIFO empty
- level_o  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- busy_o  output  1  frame in progress
- tx_bit_o  output  1  serial line, registered, idle high

Behaviour:
- Reset (rst_ni low at posedge) establishes:
  - tx_bit_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0
  - state IDLE, FIFO pointers 0, baud counter 0
- Reset mid-frame aborts the frame; the line returns high on the next cycle.
- FIFO pointers are $clog2(DEPTH)+1 bits with an extra wrap bit.
  - empty_o: pointers equal.
  - full_o: MSBs differ and remaining bits equal.
  - level_o = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- FIFO write and pop rules:
  - A write is accepted when tx_we_i && !full_o; a write while full is dropped silently.
  - A write and a pop in the same cycle both take effect; level is unchanged.
  - flush_i resets both pointers and has priority over a same-cycle write or pop.
  - Flush does not abort the frame on the line, since that word is already popped.
- Baud tick (single-cycle pulse):
  - While tx_en_i=1 the counter increments; at baud_div_i-1 it wraps to 0 and asserts tick.
  - While tx_en_i=0 the counter holds, no ticks occur, and the line holds its current bit.
  - Transmission resumes seamlessly when tx_en_i returns to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on a tick.
  - IDLE: on tick with !empty_o, pop the head word into the shift register and go to START.
    - Latch data_bits_i, parity_en_i, parity_odd_i and stop2_i at this pop.
    - Config changes mid-frame have no effect until the next frame.
  - START: line=0; next state DATA with bit counter=0.
  - DATA: line = shift LSB first. After N bits (N=5..8), go to PARITY if parity enabled, else STOP.
  - PARITY: line = XOR of the N data bits, XOR parity_odd.
  - STOP: line=1 for 1 or 2 bit times.
    - At the last stop tick: if !empty_o, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Timing:
  - tx_bit_o is registered and changes on the cycle after each tick.
  - Each bit lasts exactly baud_div_i cycles (with tx_en_i held high).
  - Frame length = (1 + N + P + S) × baud_div_i cycles.
- busy_o = (state != IDLE), registered alongside state.
- Parity computation uses only the latched N bits.

Test Plan:
- Reset, then idle 20 cycles -> tx_bit_o=1, empty_o=1, full_o=0, level_o=0, busy_o=0 throughout.
- baud_div_i=4, 8N1, write 0x55, tx_en_i=1 -> line: 4 cycles low, then 1,0,1,0,1,0,1,0 (4 cycles each), then 4 cycles high. busy_o high for exactly 40 cycles; level_o goes 1 -> 0 at pop.
- baud_div_i=3, 7 data bits, even parity, stop2=1, write 0x83 -> data 1,1,0,0,0,0,0; parity bit 0; two stop bits. Frame is 11 bits = 33 cycles; bit 7 of the input is ignored.
- baud_div_i=2, 5 data bits, odd parity, 1 stop, write 0x1F -> data 1,1,1,1,1; parity bit 0; frame 8 bits = 16 cycles.
- DEPTH=4 override, tx_en_i=0, write 0xA1..0xA5 -> full_o after 4 writes, 5th dropped, level_o=4. Then tx_en_i=1 -> four back-to-back frames with no idle bit between stop and next start, bytes in order A1..A4.
- During bit 3 of a frame, drop tx_en_i for 10 cycles -> line holds bit 3 and the frame resumes with the correct remaining bit widths. flush_i mid-frame -> current frame completes, level_o=0, FSM returns to IDLE. rst_ni low mid-frame -> tx_bit_o=1 on the next cycle.
